fpu_result_writeback: RTL and testbench
=======================================

# fpu_result_writeback

Result-side companion of the 128-bit FP adder pipeline: accepts completed results (RDY/DSTO/R/SR/flags) from the adder, buffers them in a small FIFO and drives them into the register-file write port under a request/acknowledge handshake. It also issues credits back to the dispatcher (the adder cannot stall, so issue is throttled to buffer capacity). It keeps a per-destination busy scoreboard and sticky exception status.

## Interface
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered operations; power of two, 2..16
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- ISSUE  in  1  dispatcher starts an adder op this cycle (mirrors adder ACT)
- ISSUE_DST  in  4  destination register of issued op
- ISSUE_OK  out  1  credit available; ISSUE is accepted only when high
- BUSY  out  16  scoreboard; bit d set while any accepted op targets register d
- RDY  in  1  adder result valid (single-cycle pulse per result)
- DSTI  in  4  result destination (adder DSTO)
- R  in  128  result data
- SR  in  3  result size code
- SIGN, ZERO, INF, NAN  in  1 each  result flags
- WR_REQ  out  1  write request to register file
- WR_DST  out  4  write destination
- WR_DATA  out  128  write data
- WR_SR  out  3  write size code
- WR_ACK  in  1  register file accepts current write
- STAT_CLR  in  1  clear sticky status
- STAT  out  3  sticky {OVF, NAN_SEEN, INF_SEEN}

## Operation
- Credit counter CNT (width log2(DEPTH)+1) = accepted-in-flight + FIFO occupancy. ISSUE_OK = (CNT < DEPTH), from registered CNT.
- Accepted issue = ISSUE & ISSUE_OK: CNT +1. Pop = WR_REQ & WR_ACK: CNT −1. Both same cycle: CNT unchanged. ISSUE while ISSUE_OK=0: ignored, no state change.
- Scoreboard: per-register counter (same width as CNT); BUSY[d] = counter[d] != 0. Accepted issue increments counter[ISSUE_DST]; pop decrements counter[WR_DST]; both to same d same cycle: unchanged.
- FIFO: push on RDY; entry = {DSTI, SR, R}. Pop on WR_REQ & WR_ACK. Show-ahead: WR_REQ = !empty; WR_DST/WR_DATA/WR_SR reflect head entry. Push+pop when full is legal (slot freed same cycle). Push when full without pop: result dropped, STAT[2] (OVF) set, pointers unchanged.
- Pointers wrap modulo DEPTH; separate occupancy count distinguishes full/empty.
- Sticky: RDY & NAN sets STAT[1]; RDY & INF & !NAN sets STAT[0]; OVF as above. STAT_CLR clears all three; a set event in the same cycle wins (bit stays 1).
- WR_DATA/WR_DST/WR_SR are don't-care when WR_REQ=0 but held stable while WR_REQ=1 and WR_ACK=0.

## Timing
- Reset: WR_REQ=0, WR_DST=0, WR_DATA=0, WR_SR=0, BUSY=0, STAT=0, ISSUE_OK=1, CNT=0, FIFO empty. Reset mid-operation discards buffered results and in-flight credits; results arriving afterwards from a stale pipeline push normally (dispatcher must also reset the adder).
- Result latency: RDY at edge t → WR_REQ high in cycle t+1 (FIFO empty).
- Sustained throughput one result per cycle with WR_ACK held high.
- ISSUE_OK/BUSY update one cycle after the accepting edge.

## Configuration
- FPWB_BYPASS_EN defined: when FIFO empty and RDY=1, WR_REQ and WR_* driven combinationally from RDY/DSTI/SR/R in the same cycle; if WR_ACK=1 that cycle the result is not stored (counts as push+pop). Otherwise stored as normal.
- Undefined: no combinational path from adder inputs to WR_* outputs; minimum latency one cycle.

## Test plan
- Reset, then ISSUE with ISSUE_DST=5, RDY with DSTI=5, R=128'h3FFF_0…0, WR_ACK=1 → WR_REQ one cycle after RDY with WR_DST=5, WR_DATA=R; BUSY[5] 1 from issue+1 until pop+1.
- DEPTH=4: issue 4 ops with WR_ACK=0 → ISSUE_OK=0 after 4th; fifth ISSUE ignored; one pop → ISSUE_OK=1 next cycle.
- Two issues to DST 3, results returned back-to-back, WR_ACK=1 → two writes to 3 in order; BUSY[3] clears only after second pop.
- FIFO full, RDY with WR_ACK=1 same cycle → no drop, OVF stays 0; RDY full with WR_ACK=0 → OVF=1, entry count remains 4.
- RDY with NAN=1 and INF=1 → STAT=3'b010; STAT_CLR with simultaneous RDY&INF → STAT=3'b001.
- With FPWB_BYPASS_EN, empty FIFO, RDY and WR_ACK same cycle → WR_REQ=1 that cycle, WR_DATA=R, FIFO stays empty.

Source files
------------

// File: rtl/fpu_result_writeback.sv
// rtl/fpu_result_writeback.sv - result buffer, register-file writeback, issue credits and busy scoreboard
//
// Accepts completed results from the 128-bit FP adder, buffers them in a
// DEPTH-entry show-ahead FIFO and drives them to the register-file write
// port under a WR_REQ/WR_ACK handshake. Issue credits throttle the
// dispatcher to buffer capacity because the adder cannot stall.
// Configuration macro: FPWB_BYPASS_EN (empty-FIFO result bypass to WR_*).
//
// Ports:
//   CLK, RESET           clock, synchronous active-high reset
//   ISSUE, ISSUE_DST     dispatcher issue strobe and destination register
//   ISSUE_OK             credit available (registered)
//   BUSY[15:0]           per-register pending-write scoreboard
//   RDY, DSTI, R, SR     adder result strobe, destination, data, size code
//   SIGN/ZERO/INF/NAN    adder result flags
//   WR_REQ/WR_DST/WR_DATA/WR_SR/WR_ACK  register-file write handshake
//   STAT_CLR, STAT[2:0]  sticky {OVF, NAN_SEEN, INF_SEEN} and its clear

module fpu_result_writeback #(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ISSUE,
  input  logic [3:0]   ISSUE_DST,
  output logic         ISSUE_OK,
  output logic [15:0]  BUSY,
  input  logic         RDY,
  input  logic [3:0]   DSTI,
  input  logic [127:0] R,
  input  logic [2:0]   SR,
  input  logic         SIGN,
  input  logic         ZERO,
  input  logic         INF,
  input  logic         NAN,
  output logic         WR_REQ,
  output logic [3:0]   WR_DST,
  output logic [127:0] WR_DATA,
  output logic [2:0]   WR_SR,
  input  logic         WR_ACK,
  input  logic         STAT_CLR,
  output logic [2:0]   STAT
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 4 + 3 + 128;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry layout: {dst[134:131], sr[130:128], data[127:0]}
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] sb_q [16];
  logic [CW-1:0] sb_d [16];
  logic [2:0]    stat_q, stat_d;

  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_entry;
  logic [EW-1:0] out_entry;
  logic          fifo_empty;
  logic          fifo_full;
  logic          wr_req;
  logic          byp_take;
  logic          pop;
  logic          fifo_pop;
  logic          push;
  logic          drop;
  logic          issue_ok;
  logic          issue_acc;
  logic          cnt_dec;
  logic          sb_inc;
  logic          sb_dec;

  // Sign and zero flags carry no writeback or status meaning here.
  logic unused_flags;
  assign unused_flags = SIGN ^ ZERO;

  assign issue_ok = (cnt_q < DEPTH_C);

  always_comb begin
    in_entry   = {DSTI, SR, R};
    head_entry = mem_q[rd_ptr_q];
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == DEPTH_C);
    wr_req     = !fifo_empty;
    out_entry  = head_entry;
    byp_take   = 1'b0;
`ifdef FPWB_BYPASS_EN
    // Empty FIFO: present the incoming result directly; if it is
    // acknowledged in the same cycle it never enters the FIFO.
    if (fifo_empty && RDY) begin
      wr_req    = 1'b1;
      out_entry = in_entry;
      byp_take  = WR_ACK;
    end
`endif
    pop       = wr_req & WR_ACK;
    fifo_pop  = !fifo_empty & WR_ACK;
    // A full FIFO still accepts a result when its head leaves this cycle.
    push      = RDY & !byp_take & (!fifo_full | fifo_pop);
    drop      = RDY & fifo_full & !fifo_pop;
    issue_acc = ISSUE & issue_ok;

    wr_ptr_d = push     ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    occ_d = occ_q;
    case ({push, fifo_pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
    end

    // Saturate at zero so stale results arriving after a reset cannot
    // wrap the credit or scoreboard counters.
    cnt_dec = pop && (cnt_q != '0);
    cnt_d   = cnt_q;
    case ({issue_acc, cnt_dec})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    sb_inc = 1'b0;
    sb_dec = 1'b0;
    for (int d = 0; d < 16; d++) begin
      sb_inc = issue_acc && (ISSUE_DST == 4'(d));
      sb_dec = pop && (out_entry[134:131] == 4'(d)) && (sb_q[d] != '0);
      case ({sb_inc, sb_dec})
        2'b10:   sb_d[d] = sb_q[d] + CW'(1);
        2'b01:   sb_d[d] = sb_q[d] - CW'(1);
        default: sb_d[d] = sb_q[d];
      endcase
    end

    // A set event in the clearing cycle wins.
    stat_d = STAT_CLR ? 3'b000 : stat_q;
    stat_d = stat_d | {drop, RDY & NAN, RDY & INF & !NAN};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      stat_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      for (int d = 0; d < 16; d++) begin
        sb_q[d] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      stat_q   <= stat_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      for (int d = 0; d < 16; d++) begin
        sb_q[d] <= sb_d[d];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 16; d++) begin
      BUSY[d] = (sb_q[d] != '0);
    end
  end

  // Write-port fields are forced to zero while idle so the post-reset
  // state is defined without resetting through the read mux.
  assign ISSUE_OK = issue_ok;
  assign WR_REQ   = wr_req;
  assign WR_DST   = wr_req ? out_entry[134:131] : 4'd0;
  assign WR_SR    = wr_req ? out_entry[130:128] : 3'd0;
  assign WR_DATA  = wr_req ? out_entry[127:0]   : 128'd0;
  assign STAT     = stat_q;

endmodule

// File: tb/tb_fpu_result_writeback.sv
// tb/tb_fpu_result_writeback.sv - scoreboard bench for fpu_result_writeback

module tb_fpu_result_writeback;

  typedef struct packed {
    logic [3:0]   dst;
    logic [2:0]   sr;
    logic [127:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         issue;
  logic [3:0]   issue_dst;
  logic         issue_ok;
  logic [15:0]  busy;
  logic         rdy;
  logic [3:0]   dsti;
  logic [127:0] r;
  logic [2:0]   sr;
  logic         sign, zero, inf, nan;
  logic         wr_req;
  logic [3:0]   wr_dst;
  logic [127:0] wr_data;
  logic [2:0]   wr_sr;
  logic         wr_ack;
  logic         stat_clr;
  logic [2:0]   stat;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  fpu_result_writeback #(.DEPTH(4)) dut (
    .CLK(clk), .RESET(reset),
    .ISSUE(issue), .ISSUE_DST(issue_dst), .ISSUE_OK(issue_ok), .BUSY(busy),
    .RDY(rdy), .DSTI(dsti), .R(r), .SR(sr),
    .SIGN(sign), .ZERO(zero), .INF(inf), .NAN(nan),
    .WR_REQ(wr_req), .WR_DST(wr_dst), .WR_DATA(wr_data), .WR_SR(wr_sr),
    .WR_ACK(wr_ack), .STAT_CLR(stat_clr), .STAT(stat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue = 0; issue_dst = 0; rdy = 0; dsti = 0; r = '0; sr = 0;
    sign = 0; zero = 0; inf = 0; nan = 0; wr_ack = 0; stat_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    exp_q.delete();
  endtask

  // Drives one adder result for the current cycle; when keep is set the
  // result is also expected to reach the write port in order.
  task automatic drive_rdy(input logic [3:0] d, input logic [2:0] s,
                           input logic [127:0] data, input logic f_nan,
                           input logic f_inf, input bit keep);
    wr_t e;
    rdy = 1; dsti = d; sr = s; r = data; nan = f_nan; inf = f_inf;
    e.dst = d; e.sr = s; e.data = data;
    if (keep) exp_q.push_back(e);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL reset_wr_req got=%0b exp=0", wr_req); end
    total++; if ({wr_dst, wr_sr} !== 7'd0) begin bad++; $display("FAIL reset_wr_dst_sr got=%0h exp=0", {wr_dst, wr_sr}); end
    total++; if (wr_data !== 128'd0) begin bad++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
    total++; if (busy !== 16'd0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (stat !== 3'd0) begin bad++; $display("FAIL reset_stat got=%0b exp=000", stat); end
    total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL reset_issue_ok got=%0b exp=1", issue_ok); end
  endtask

  task automatic test_basic();
    wr_t e, got;
    do_reset();
    tick(); issue = 1; issue_dst = 5;
    @(negedge clk);
    total++; if (busy[5] !== 1'b0) begin bad++; $display("FAIL basic_busy_pre got=%0b exp=0", busy[5]); end
    tick(); issue = 0;
    @(negedge clk);
    total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL basic_busy_set got=%0b exp=1", busy[5]); end
    tick(); drive_rdy(4'd5, 3'd2, 128'h3FFF0000_00000000_00000000_00000000, 0, 0, 1); wr_ack = 1;
`ifndef FPWB_BYPASS_EN
    @(negedge clk);
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL basic_latency got=%0b exp=0", wr_req); end
`else
    @(negedge clk);
`endif
    tick(); rdy = 0;
`ifndef FPWB_BYPASS_EN
    @(negedge clk);
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL basic_wr_req got=%0b exp=1", wr_req); end
    if (exp_q.size() == 0) begin total++; bad++; $display("FAIL basic_write got=write exp=none"); end
    else begin
      e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
      total++; if (got !== e) begin bad++; $display("FAIL basic_write got=%0h exp=%0h", got, e); end
    end
    total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL basic_busy_hold got=%0b exp=1", busy[5]); end
    tick();
`endif
    @(negedge clk);
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL basic_idle got=%0b exp=0", wr_req); end
    total++; if (busy[5] !== 1'b0) begin bad++; $display("FAIL basic_busy_clr got=%0b exp=0", busy[5]); end
    wr_ack = 0;
    exp_q.delete();
  endtask

  task automatic test_credit();
    wr_t e, got;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); issue = 1; issue_dst = 4'(i);
      @(negedge clk);
      total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL credit_ok_pre%0d got=%0b exp=1", i, issue_ok); end
    end
    tick(); issue = 1; issue_dst = 7;
    @(negedge clk);
    total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL credit_full got=%0b exp=0", issue_ok); end
    tick(); issue = 0;
    @(negedge clk);
    total++; if (busy !== 16'h000F) begin bad++; $display("FAIL credit_busy got=%0h exp=000f", busy); end
    tick(); drive_rdy(4'd0, 3'd1, rand128(), 0, 0, 1);
    @(negedge clk);
    tick(); rdy = 0; wr_ack = 1;
    @(negedge clk);
    if (wr_req !== 1'b1 || exp_q.size() == 0) begin total++; bad++; $display("FAIL credit_pop got=%0b exp=1", wr_req); end
    else begin
      e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
      total++; if (got !== e) begin bad++; $display("FAIL credit_pop got=%0h exp=%0h", got, e); end
    end
    total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL credit_ok_before got=%0b exp=0", issue_ok); end
    tick(); wr_ack = 0;
    @(negedge clk);
    total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL credit_ok_after got=%0b exp=1", issue_ok); end
    total++; if (busy !== 16'h000E) begin bad++; $display("FAIL credit_busy_pop got=%0h exp=000e", busy); end
    for (int i = 1; i < 4; i++) begin
      tick(); drive_rdy(4'(i), 3'(i), rand128(), 0, 0, 1);
      @(negedge clk);
    end
    tick(); rdy = 0; wr_ack = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wr_req === 1'b1) begin
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL credit_drain got=extra exp=none"); end
        else begin
          e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
          total++; if (got !== e) begin bad++; $display("FAIL credit_drain got=%0h exp=%0h", got, e); end
        end
      end
      tick();
    end
    @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL credit_left got=%0d exp=0", exp_q.size()); end
    total++; if (busy !== 16'd0) begin bad++; $display("FAIL credit_busy_end got=%0h exp=0", busy); end
    wr_ack = 0;
  endtask

  task automatic test_back_to_back();
    wr_t e, got;
    do_reset();
    tick(); issue = 1; issue_dst = 3;
    @(negedge clk);
    tick(); issue_dst = 3;
    @(negedge clk);
    tick(); issue = 0; drive_rdy(4'd3, 3'd4, rand128(), 0, 0, 1);
    @(negedge clk);
    tick(); drive_rdy(4'd3, 3'd5, rand128(), 0, 0, 1); wr_ack = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        total++; if (busy[3] !== 1'b1) begin bad++; $display("FAIL b2b_busy_mid got=%0b exp=1", busy[3]); end
      end
      if (wr_req !== 1'b1 || exp_q.size() == 0) begin total++; bad++; $display("FAIL b2b_write%0d got=%0b exp=1", k, wr_req); end
      else begin
        e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
        total++; if (got !== e) begin bad++; $display("FAIL b2b_write%0d got=%0h exp=%0h", k, got, e); end
      end
      tick(); rdy = 0;
      @(negedge clk);
    end
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", wr_req); end
    total++; if (busy[3] !== 1'b0) begin bad++; $display("FAIL b2b_busy_clr got=%0b exp=0", busy[3]); end
    wr_ack = 0;
  endtask

  task automatic test_overflow();
    wr_t e, got;
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); drive_rdy(4'd1, 3'(i), rand128(), 0, 0, 1);
      @(negedge clk);
    end
    tick(); drive_rdy(4'd1, 3'd6, rand128(), 0, 0, 1); wr_ack = 1;
    @(negedge clk);
    if (wr_req !== 1'b1) begin total++; bad++; $display("FAIL ovf_full_req got=%0b exp=1", wr_req); end
    else begin
      e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
      total++; if (got !== e) begin bad++; $display("FAIL ovf_pushpop_head got=%0h exp=%0h", got, e); end
    end
    tick(); wr_ack = 0; drive_rdy(4'd1, 3'd7, rand128(), 0, 0, 0);
    @(negedge clk);
    total++; if (stat[2] !== 1'b0) begin bad++; $display("FAIL ovf_no_drop got=%0b exp=0", stat[2]); end
    tick(); rdy = 0;
    @(negedge clk);
    total++; if (stat !== 3'b100) begin bad++; $display("FAIL ovf_set got=%0b exp=100", stat); end
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); wr_ack = 1;
      @(negedge clk);
      if (wr_req === 1'b1) begin
        n++;
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL ovf_drain got=extra exp=none"); end
        else begin
          e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
          total++; if (got !== e) begin bad++; $display("FAIL ovf_drain got=%0h exp=%0h", got, e); end
        end
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", n); end
    wr_ack = 0;
  endtask

  task automatic test_status();
    wr_t e, got;
    do_reset();
    tick(); drive_rdy(4'd0, 3'd0, rand128(), 1, 1, 1);
    @(negedge clk);
    tick(); rdy = 0; nan = 0; inf = 0; wr_ack = 1;
    @(negedge clk);
    total++; if (stat !== 3'b010) begin bad++; $display("FAIL stat_nan got=%0b exp=010", stat); end
    if (wr_req !== 1'b1 || exp_q.size() == 0) begin total++; bad++; $display("FAIL stat_write0 got=%0b exp=1", wr_req); end
    else begin
      e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
      total++; if (got !== e) begin bad++; $display("FAIL stat_write0 got=%0h exp=%0h", got, e); end
    end
    tick(); wr_ack = 0; stat_clr = 1; drive_rdy(4'd2, 3'd3, rand128(), 0, 1, 1);
    @(negedge clk);
    tick(); stat_clr = 0; rdy = 0; inf = 0; wr_ack = 1;
    @(negedge clk);
    total++; if (stat !== 3'b001) begin bad++; $display("FAIL stat_clr_inf got=%0b exp=001", stat); end
    if (wr_req !== 1'b1 || exp_q.size() == 0) begin total++; bad++; $display("FAIL stat_write1 got=%0b exp=1", wr_req); end
    else begin
      e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
      total++; if (got !== e) begin bad++; $display("FAIL stat_write1 got=%0h exp=%0h", got, e); end
    end
    tick(); wr_ack = 0; stat_clr = 1;
    @(negedge clk);
    tick(); stat_clr = 0;
    @(negedge clk);
    total++; if (stat !== 3'b000) begin bad++; $display("FAIL stat_clear got=%0b exp=000", stat); end
  endtask

`ifdef FPWB_BYPASS_EN
  task automatic test_bypass();
    wr_t e, got;
    do_reset();
    tick(); drive_rdy(4'd9, 3'd2, rand128(), 0, 0, 1); wr_ack = 1;
    @(negedge clk);
    if (wr_req !== 1'b1) begin total++; bad++; $display("FAIL bypass_req got=%0b exp=1", wr_req); end
    else begin
      e = exp_q.pop_front(); got = {wr_dst, wr_sr, wr_data};
      total++; if (got !== e) begin bad++; $display("FAIL bypass_data got=%0h exp=%0h", got, e); end
    end
    tick(); rdy = 0;
    @(negedge clk);
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL bypass_empty got=%0b exp=0", wr_req); end
    wr_ack = 0;
  endtask
`endif

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_basic();
    test_credit();
    test_back_to_back();
    test_overflow();
    test_status();
`ifdef FPWB_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
